// File: rtl/metronome_beat_scheduler.sv
// Beat sequencer for the metronome: beat timing, deferred tempo/bar/accent
// configuration, start/stop control and the gated speaker tone.
module metronome_beat_scheduler #(
    parameter int unsigned DEFAULT_PERIOD = 27000000,
    parameter int unsigned DEFAULT_BEATS  = 8,
    parameter int unsigned MIN_PERIOD     = 2700000,
    parameter int unsigned BEEP_CYCLES    = 5400000,
    parameter int unsigned NORMAL_HALF    = 48704,
    parameter int unsigned ACCENT_HALF    = 32507
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        cfg_valid,
    input  logic [26:0] cfg_period,
    input  logic [3:0]  cfg_beats,
    input  logic [3:0]  cfg_accent,
    output logic [3:0]  beat_idx,
    output logic        beat_tick,
    output logic        accent,
    output logic        speaker_out,
    output logic        running
);

    localparam int unsigned PW = 27;
    localparam int unsigned TW = 17;
    localparam int unsigned BW = 4;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [TW-1:0]   tone_cnt_q, tone_cnt_d;
    logic [BW-1:0]   beat_idx_q, beat_idx_d;
    logic            beat_tick_q, beat_tick_d;
    logic            accent_q, accent_d;
    logic            speaker_q, speaker_d;
    logic            running_q, running_d;
    logic [PW-1:0]   period_q, period_d;
    logic [BW-1:0]   beats_q, beats_d;
    logic [BW-1:0]   accent_sel_q, accent_sel_d;
    logic            pend_q, pend_d;
    logic [PW-1:0]   pend_period_q, pend_period_d;
    logic [BW-1:0]   pend_beats_q, pend_beats_d;
    logic [BW-1:0]   pend_accent_q, pend_accent_d;

    logic            cfg_ok;
    logic [PW-1:0]   cap_period;
    logic [BW-1:0]   cap_accent;
    logic            restart;
    logic            boundary;
    logic            apply_now;
    logic [BW-1:0]   next_idx;
    logic [TW-1:0]   half_m1;

    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        tone_cnt_d     = tone_cnt_q;
        beat_idx_d     = beat_idx_q;
        beat_tick_d    = 1'b0;
        accent_d       = accent_q;
        speaker_d      = speaker_q;
        running_d      = running_q;
        period_d       = period_q;
        beats_d        = beats_q;
        accent_sel_d   = accent_sel_q;
        pend_d         = pend_q;
        pend_period_d  = pend_period_q;
        pend_beats_d   = pend_beats_q;
        pend_accent_d  = pend_accent_q;

        cfg_ok     = cfg_valid && (cfg_beats != '0) && (cfg_beats <= BW'(8));
        cap_period = (cfg_period < PW'(MIN_PERIOD)) ? PW'(MIN_PERIOD) : cfg_period;
        cap_accent = (cfg_accent > BW'(8)) ? '0 : cfg_accent;
        restart    = start && !stop;
        boundary   = (state_q == RUN) && !stop && !start && (phase_q == period_q - PW'(1));
        apply_now  = (state_q == IDLE) || boundary || restart;

        // Config lands directly when it can take effect now, otherwise waits for the next beat.
        if (cfg_ok) begin
            if (apply_now) begin
                period_d     = cap_period;
                beats_d      = cfg_beats;
                accent_sel_d = cap_accent;
                pend_d       = 1'b0;
            end else begin
                pend_period_d = cap_period;
                pend_beats_d  = cfg_beats;
                pend_accent_d = cap_accent;
                pend_d        = 1'b1;
            end
        end else if (pend_q && (boundary || restart)) begin
            period_d     = pend_period_q;
            beats_d      = pend_beats_q;
            accent_sel_d = pend_accent_q;
            pend_d       = 1'b0;
        end

        next_idx = (beat_idx_q >= beats_d) ? BW'(1) : beat_idx_q + BW'(1);
        half_m1  = accent_q ? TW'(ACCENT_HALF - 1) : TW'(NORMAL_HALF - 1);

        if (stop) begin
            state_d    = IDLE;
            phase_d    = '0;
            tone_cnt_d = '0;
            beat_idx_d = '0;
            accent_d   = 1'b0;
            speaker_d  = 1'b0;
            running_d  = 1'b0;
        end else if (start) begin
            state_d     = RUN;
            phase_d     = '0;
            tone_cnt_d  = '0;
            beat_idx_d  = BW'(1);
            beat_tick_d = 1'b1;
            accent_d    = (accent_sel_d == BW'(1));
            speaker_d   = 1'b1;
            running_d   = 1'b1;
        end else if (state_q == RUN) begin
            if (boundary) begin
                phase_d     = '0;
                tone_cnt_d  = '0;
                beat_idx_d  = next_idx;
                beat_tick_d = 1'b1;
                accent_d    = (next_idx == accent_sel_d);
                speaker_d   = 1'b1;
            end else begin
                phase_d = phase_q + PW'(1);
                // Tone is gated by the phase of the cycle being entered.
                if (phase_d >= PW'(BEEP_CYCLES)) begin
                    speaker_d  = 1'b0;
                    tone_cnt_d = '0;
                end else if (tone_cnt_q == half_m1) begin
                    speaker_d  = !speaker_q;
                    tone_cnt_d = '0;
                end else begin
                    tone_cnt_d = tone_cnt_q + TW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            phase_q       <= '0;
            tone_cnt_q    <= '0;
            beat_idx_q    <= '0;
            beat_tick_q   <= 1'b0;
            accent_q      <= 1'b0;
            speaker_q     <= 1'b0;
            running_q     <= 1'b0;
            period_q      <= PW'(DEFAULT_PERIOD);
            beats_q       <= BW'(DEFAULT_BEATS);
            accent_sel_q  <= BW'(DEFAULT_BEATS);
            pend_q        <= 1'b0;
            pend_period_q <= '0;
            pend_beats_q  <= '0;
            pend_accent_q <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            tone_cnt_q    <= tone_cnt_d;
            beat_idx_q    <= beat_idx_d;
            beat_tick_q   <= beat_tick_d;
            accent_q      <= accent_d;
            speaker_q     <= speaker_d;
            running_q     <= running_d;
            period_q      <= period_d;
            beats_q       <= beats_d;
            accent_sel_q  <= accent_sel_d;
            pend_q        <= pend_d;
            pend_period_q <= pend_period_d;
            pend_beats_q  <= pend_beats_d;
            pend_accent_q <= pend_accent_d;
        end
    end

    assign beat_idx    = beat_idx_q;
    assign beat_tick   = beat_tick_q;
    assign accent      = accent_q;
    assign speaker_out = speaker_q;
    assign running     = running_q;

endmodule
